// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard receiver: synchronises ps2_clk/ps2_data, deserialises
// 11-bit frames, folds E0/F0 prefixes into {ext, brk, code} events and
// buffers them in a power-of-two first-word-fall-through FIFO.
//
// Ports:
//   clk        system clock
//   clrn       synchronous active-low reset
//   ps2_clk    PS/2 clock from keyboard (async)
//   ps2_data   PS/2 data from keyboard (async)
//   nextdata_n active-low pop, honoured when ready is high
//   data       head-of-FIFO scan code
//   ext        head event had an E0 prefix
//   brk        head event had an F0 prefix (key release)
//   ready      FIFO non-empty
//   overflow   sticky: an event was dropped on a full FIFO
//   frame_err  one-cycle pulse on a bad frame or a mid-frame timeout
//
// Optional build macro PS2_TYPEMATIC_FILTER_EN: discard make events that
// repeat the last pushed make {ext, code} (typematic auto-repeat).

module ps2_kbd_rx_fifo #(
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 50000,
   parameter int SYNC_STAGES = 3
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   output logic [7:0] data,
   output logic       ext,
   output logic       brk,
   output logic       ready,
   output logic       overflow,
   output logic       frame_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC - 1);

   // ------------------------------------------------------------------
   // Input synchronisers and falling-edge strobe
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic                   clk_prev;
   logic                   strobe;
   logic                   bit_in;

   // Reset to the idle-high line level so reset release never
   // fabricates a falling edge.
   always_ff @(posedge clk) begin
      if (!clrn) begin
         clk_sync <= '1;
         dat_sync <= '1;
         clk_prev <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
         clk_prev <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign strobe = clk_prev & ~clk_sync[SYNC_STAGES-1];
   assign bit_in = dat_sync[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t          state;
   logic [3:0]      bit_cnt;
   logic [9:0]      frame;
   logic [TW-1:0]   tmo_cnt;
   logic            frame_ok;
   logic            ext_pend;
   logic            brk_pend;
   logic            is_e0;
   logic            is_f0;

   assign is_e0 = (frame[7:0] == 8'hE0);
   assign is_f0 = (frame[7:0] == 8'hF0);

   // Frame bits shift in from the top. Before the stop strobe, the
   // 8 data bits plus parity sit in frame[9:1], so the verdict is
   // registered on that strobe and frame_err lands in the CHECK cycle.
   always_ff @(posedge clk) begin
      if (!clrn) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         frame     <= '0;
         tmo_cnt   <= '0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         ext_pend  <= 1'b0;
         brk_pend  <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         unique case (state)
            IDLE: begin
               tmo_cnt <= '0;
               if (strobe && !bit_in) begin
                  state   <= SHIFT;
                  bit_cnt <= 4'd1;
               end
            end
            SHIFT: begin
               if (strobe) begin
                  tmo_cnt <= '0;
                  frame   <= {bit_in, frame[9:1]};
                  if (bit_cnt == 4'd10) begin
                     state     <= CHECK;
                     frame_ok  <= bit_in & (^frame[9:1]);
                     frame_err <= ~(bit_in & (^frame[9:1]));
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end else if (tmo_cnt == TMO_MAX) begin
                  // Stalled frame: drop it, keep any prefix state.
                  state     <= IDLE;
                  frame_err <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            CHECK: begin
               state <= IDLE;
               if (!frame_ok) begin
                  ext_pend <= 1'b0;
                  brk_pend <= 1'b0;
               end else if (is_e0) begin
                  ext_pend <= 1'b1;
               end else if (is_f0) begin
                  brk_pend <= 1'b1;
               end else begin
                  ext_pend <= 1'b0;
                  brk_pend <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Event generation and optional typematic filter
   // ------------------------------------------------------------------
   logic       evt_en;
   logic [9:0] evt;
   logic       push;

   assign evt_en = (state == CHECK) & frame_ok & ~is_e0 & ~is_f0;
   assign evt    = {ext_pend, brk_pend, frame[7:0]};

`ifdef PS2_TYPEMATIC_FILTER_EN
   logic       rec_vld;
   logic [8:0] rec;
   logic       repeat_hit;

   assign repeat_hit = rec_vld & ~brk_pend & (rec == {ext_pend, frame[7:0]});
   assign push       = evt_en & ~repeat_hit;

   // A break forgets the held key so the next press of it is pushed.
   always_ff @(posedge clk) begin
      if (!clrn) begin
         rec_vld <= 1'b0;
         rec     <= '0;
      end else if (evt_en) begin
         if (brk_pend) begin
            rec_vld <= 1'b0;
         end else begin
            rec_vld <= 1'b1;
            rec     <= {ext_pend, frame[7:0]};
         end
      end
   end
`else
   assign push = evt_en;
`endif

   // ------------------------------------------------------------------
   // Event FIFO
   // ------------------------------------------------------------------
   logic [9:0]    mem [FIFO_DEPTH];
   logic [AW:0]   wp;
   logic [AW:0]   rp;
   logic          empty;
   logic          full;
   logic          pop;
   logic [AW-1:0] rd_idx;

   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign pop   = ~nextdata_n & ~empty;

   // A pop in the same cycle frees the slot the push needs.
   always_ff @(posedge clk) begin
      if (!clrn) begin
         wp       <= '0;
         rp       <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (pop) begin
            rp <= rp + 1'b1;
         end
         if (push) begin
            if (!full || pop) begin
               mem[wp[AW-1:0]] <= evt;
               wp              <= wp + 1'b1;
            end else begin
               overflow <= 1'b1;
            end
         end
      end
   end

   // When empty, present the most recently popped entry.
   assign rd_idx = empty ? (rp[AW-1:0] - AW'(1)) : rp[AW-1:0];
   assign {ext, brk, data} = mem[rd_idx];
   assign ready = ~empty;

endmodule

// File: tb/tb_ps2_kbd_rx_fifo.sv
// Scoreboard bench for ps2_kbd_rx_fifo: directed PS/2 frames,
// expected events queued at stimulus time, popped by a monitor.

module tb_ps2_kbd_rx_fifo;

   localparam int TMO = 200;

   logic       clk;
   logic       clrn;
   logic       ps2_clk;
   logic       ps2_data;
   logic       nextdata_n;
   logic [7:0] data;
   logic       ext;
   logic       brk;
   logic       ready;
   logic       overflow;
   logic       frame_err;

   ps2_kbd_rx_fifo #(
      .FIFO_DEPTH  (8),
      .TIMEOUT_CYC (TMO),
      .SYNC_STAGES (3)
   ) dut (
      .clk        (clk),
      .clrn       (clrn),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .nextdata_n (nextdata_n),
      .data       (data),
      .ext        (ext),
      .brk        (brk),
      .ready      (ready),
      .overflow   (overflow),
      .frame_err  (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         checks = 0;
   int         passes = 0;
   int         err_cnt = 0;
   bit         auto_pop = 1'b0;
   logic [9:0] exp_q[$];

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got == want) passes++;
      else $display("FAIL %s: got %0h want %0h", name, got, want);
   endtask

   task automatic expect_evt(input bit e, input bit b, input logic [7:0] c);
      exp_q.push_back({e, b, c});
   endtask

   // Scoreboard monitor: compare the head, then pop it at the next edge.
   initial begin
      logic [9:0] e;
      nextdata_n = 1'b1;
      forever begin
         @(negedge clk);
         if (auto_pop && ready && clrn) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_event", {ext, brk, data}, 10'h3FF);
            end else begin
               e = exp_q.pop_front();
               chk("event", {ext, brk, data}, e);
            end
            nextdata_n = 1'b0;
         end else begin
            nextdata_n = 1'b1;
         end
      end
   end

   // frame_err pulse counter; a pulse must last exactly one cycle.
   initial begin
      bit prev = 1'b0;
      forever begin
         @(negedge clk);
         if (frame_err) begin
            err_cnt++;
            if (prev) chk("frame_err_width", 2, 1);
         end
         prev = frame_err;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // One PS/2 bit; lat = negedges after the falling ps2_clk edge at
   // which ready was first seen high (0 if never).
   task automatic send_bit(input bit b, output int lat);
      lat = 0;
      ps2_data = b;
      repeat (5) @(negedge clk);
      ps2_clk = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (ready && lat == 0) lat = k;
      end
      ps2_clk = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] c, input bit bad_par,
                             output int lat);
      int  l;
      bit  par;
      par = ~(^c) ^ bad_par;
      send_bit(1'b0, l);
      for (int i = 0; i < 8; i++) send_bit(c[i], l);
      send_bit(par, l);
      send_bit(1'b1, lat);
      ps2_data = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] c);
      int l;
      send_frame(c, 1'b0, l);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
      chk(name, exp_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int lat;
      int e0;
      int l;
      clrn     = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_data", data, 0);
      chk("rst_ext", ext, 0);
      chk("rst_brk", brk, 0);
      chk("rst_ready", ready, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_frame_err", frame_err, 0);
      clrn = 1'b1;
      repeat (4) @(negedge clk);

      // Single make code, latency from stop-bit falling edge.
      e0 = err_cnt;
      expect_evt(0, 0, 8'h1C);
      send_frame(8'h1C, 1'b0, lat);
      chk("latency_1c", lat, 5);
      auto_pop = 1'b1;
      drain("drain_1c");
      chk("no_err_1c", err_cnt - e0, 0);

      // Extended break, then plain make.
      expect_evt(1, 1, 8'h75);
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      expect_evt(0, 0, 8'h1B);
      send(8'h1B);
      drain("drain_prefix");

      // Bad parity.
      e0 = err_cnt;
      send_frame(8'h1C, 1'b1, l);
      chk("parity_err", err_cnt - e0, 1);
      chk("parity_ready", ready, 0);
      expect_evt(0, 0, 8'h1B);
      send(8'h1B);
      drain("drain_after_parity");
      chk("parity_err_once", err_cnt - e0, 1);

      // Partial frame then timeout.
      e0 = err_cnt;
      send_bit(1'b0, l);
      for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b0 : 1'b0, l);
      ps2_data = 1'b1;
      repeat (TMO + 100) @(negedge clk);
      chk("timeout_err", err_cnt - e0, 1);
      expect_evt(0, 0, 8'h1C);
      send(8'h1C);
      drain("drain_after_timeout");
      chk("timeout_err_once", err_cnt - e0, 1);

      // Overflow: nine codes into an eight-deep FIFO.
      chk("overflow_clear", overflow, 0);
      auto_pop = 1'b0;
      for (int v = 1; v <= 9; v++) begin
         if (v <= 8) expect_evt(0, 0, v[7:0]);
         send(v[7:0]);
      end
      chk("overflow_set", overflow, 1);
      chk("full_ready", ready, 1);
      auto_pop = 1'b1;
      drain("drain_overflow");
      chk("empty_ready", ready, 0);
      chk("overflow_sticky", overflow, 1);

      // Typematic repeats.
      expect_evt(0, 0, 8'h1B);
`ifndef PS2_TYPEMATIC_FILTER_EN
      expect_evt(0, 0, 8'h1B);
      expect_evt(0, 0, 8'h1B);
`endif
      expect_evt(0, 1, 8'h1B);
      send(8'h1B);
      send(8'h1B);
      send(8'h1B);
      send(8'hF0);
      send(8'h1B);
      drain("drain_typematic");
      chk("final_ready", ready, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
